// File: rtl/fp_addsub_special_pipe.sv
// rtl/fp_addsub_special_pipe.sv - two-stage IEEE-754 add/sub special-operand resolver
// Stage 1 classifies both operands; stage 2 applies the NaN/Inf/zero priority rules.
module fp_addsub_special_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     in_a,
  input  logic [EXP_W+MAN_W:0]     in_b,
  input  logic                     in_sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_q,
  output logic                     out_exc,
  output logic                     flag_nv,
  input  logic                     flag_clr
);

  localparam int W = 1 + EXP_W + MAN_W;

  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W-1:0] man_a, man_b;
  logic             c_a_zero, c_a_inf, c_a_qnan, c_a_snan;
  logic             c_b_zero, c_b_inf, c_b_qnan, c_b_snan;

  logic             s1_v, s1_eb;
  logic [W-1:0]     s1_a, s1_b;
  logic             s1_a_zero, s1_a_inf, s1_a_qnan, s1_a_snan;
  logic             s1_b_zero, s1_b_inf, s1_b_qnan, s1_b_snan;

  logic             s2_v, s2_exc, s2_nv;
  logic [W-1:0]     s2_q;

  logic             s1_adv;
  logic [W-1:0]     r_q;
  logic             r_exc, r_nv;
  logic             a_nan, b_nan;

  assign s1_adv   = !s2_v || out_ready;
  assign in_ready = !s1_v || s1_adv;

  assign out_valid = s2_v;
  assign out_q     = s2_q;
  assign out_exc   = s2_exc;

  assign exp_a = in_a[W-2 -: EXP_W];
  assign exp_b = in_b[W-2 -: EXP_W];
  assign man_a = in_a[MAN_W-1:0];
  assign man_b = in_b[MAN_W-1:0];

  // Quiet vs signalling NaN is decided by the top stored mantissa bit.
  assign c_a_zero = (exp_a == '0) && (man_a == '0);
  assign c_a_inf  = (&exp_a) && (man_a == '0);
  assign c_a_qnan = (&exp_a) && man_a[MAN_W-1];
  assign c_a_snan = (&exp_a) && !man_a[MAN_W-1] && (man_a != '0);
  assign c_b_zero = (exp_b == '0) && (man_b == '0);
  assign c_b_inf  = (&exp_b) && (man_b == '0);
  assign c_b_qnan = (&exp_b) && man_b[MAN_W-1];
  assign c_b_snan = (&exp_b) && !man_b[MAN_W-1] && (man_b != '0);

  assign a_nan = s1_a_qnan || s1_a_snan;
  assign b_nan = s1_b_qnan || s1_b_snan;

  always_comb begin
    r_q   = '0;
    r_exc = 1'b1;
    r_nv  = 1'b0;
    if (a_nan || b_nan) begin
      r_q            = a_nan ? s1_a : s1_b;
      r_q[MAN_W-1]   = 1'b1;
      r_nv           = s1_a_snan || s1_b_snan;
    end else if (s1_a_inf && s1_b_inf && (s1_a[W-1] != s1_eb)) begin
      r_q  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      r_nv = 1'b1;
    end else if (s1_a_inf) begin
      r_q = {s1_a[W-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (s1_b_inf) begin
      r_q = {s1_eb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (s1_a_zero && s1_b_zero) begin
      // Exact zero sum under round-to-nearest is -0 only when both addends are -0.
      r_q = {s1_a[W-1] & s1_eb, {(W-1){1'b0}}};
    end else if (s1_a_zero) begin
      r_q = {s1_eb, s1_b[W-2:0]};
    end else if (s1_b_zero) begin
      r_q = s1_a;
    end else begin
      r_exc = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v      <= 1'b0;
      s1_eb     <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_a_zero <= 1'b0;
      s1_a_inf  <= 1'b0;
      s1_a_qnan <= 1'b0;
      s1_a_snan <= 1'b0;
      s1_b_zero <= 1'b0;
      s1_b_inf  <= 1'b0;
      s1_b_qnan <= 1'b0;
      s1_b_snan <= 1'b0;
      s2_v      <= 1'b0;
      s2_q      <= '0;
      s2_exc    <= 1'b0;
      s2_nv     <= 1'b0;
      flag_nv   <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_v <= in_valid;
        if (in_valid) begin
          s1_a      <= in_a;
          s1_b      <= in_b;
          s1_eb     <= in_b[W-1] ^ in_sub;
          s1_a_zero <= c_a_zero;
          s1_a_inf  <= c_a_inf;
          s1_a_qnan <= c_a_qnan;
          s1_a_snan <= c_a_snan;
          s1_b_zero <= c_b_zero;
          s1_b_inf  <= c_b_inf;
          s1_b_qnan <= c_b_qnan;
          s1_b_snan <= c_b_snan;
        end
      end
      if (s1_adv) begin
        s2_v <= s1_v;
        if (s1_v) begin
          s2_q   <= r_q;
          s2_exc <= r_exc;
          s2_nv  <= r_nv;
        end
      end
      // A set on the same cycle as a clear takes priority.
      if (s2_v && out_ready && s2_nv) begin
        flag_nv <= 1'b1;
      end else if (flag_clr) begin
        flag_nv <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp_addsub_special_pipe.sv
// tb/tb_fp_addsub_special_pipe.sv - directed bench for fp_addsub_special_pipe
// Half-precision instance for most vectors, single-precision instance for the last.
module tb_fp_addsub_special_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_sub, out_valid, out_ready, out_exc, flag_nv, flag_clr;
  logic [15:0] in_a, in_b, out_q;

  logic        d_in_valid, d_in_ready, d_in_sub, d_out_valid, d_out_ready, d_out_exc;
  logic        d_flag_nv, d_flag_clr;
  logic [31:0] d_in_a, d_in_b, d_out_q;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_addsub_special_pipe #(.EXP_W(5), .MAN_W(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .out_valid(out_valid),
    .out_ready(out_ready), .out_q(out_q), .out_exc(out_exc),
    .flag_nv(flag_nv), .flag_clr(flag_clr)
  );

  fp_addsub_special_pipe #(.EXP_W(8), .MAN_W(23)) dut_d (
    .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_a(d_in_a), .in_b(d_in_b), .in_sub(d_in_sub), .out_valid(d_out_valid),
    .out_ready(d_out_ready), .out_q(d_out_q), .out_exc(d_out_exc),
    .flag_nv(d_flag_nv), .flag_clr(d_flag_clr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_beat(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input logic [15:0] eq, input logic eexc,
                         input logic env);
    @(negedge clk);
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_q"}, 64'(out_q), 64'(eq));
    chk({tag, "_exc"}, 64'(out_exc), 64'(eexc));
    @(negedge clk);
    chk({tag, "_nv"}, 64'(flag_nv), 64'(env));
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    chk({tag, "_nvclr"}, 64'(flag_nv), 64'd0);
  endtask

  logic [15:0] stream_a [4];
  int n_acc, n_rx;
  logic fire_in, fire_out;

  initial begin
    stream_a[0] = 16'h3C00; stream_a[1] = 16'h4000;
    stream_a[2] = 16'h4200; stream_a[3] = 16'h4400;
    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b1; flag_clr = 1'b0;
    d_in_valid = 1'b0; d_in_a = '0; d_in_b = '0; d_in_sub = 1'b0; d_out_ready = 1'b1;
    d_flag_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_q", 64'(out_q), 64'd0);
    chk("rst_out_exc", 64'(out_exc), 64'd0);
    chk("rst_flag_nv", 64'(flag_nv), 64'd0);
    rst = 1'b0;

    do_beat("t1_inf_minus_inf", 16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 1'b1, 1'b1);
    do_beat("t2_b_negzero",     16'h3C00, 16'h8000, 1'b1, 16'h3C00, 1'b1, 1'b0);
    do_beat("t2_zero_zero",     16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    do_beat("t2_nzero_zero",    16'h8000, 16'h0000, 1'b1, 16'h8000, 1'b1, 1'b0);
    do_beat("t3_snan_a",        16'h7D00, 16'h3C00, 1'b0, 16'h7F00, 1'b1, 1'b1);
    do_beat("t3_qnan_b",        16'h3C00, 16'hFE01, 1'b0, 16'hFE01, 1'b1, 1'b0);
    do_beat("t4_normal",        16'h3C00, 16'h4000, 1'b0, 16'h0000, 1'b0, 1'b0);
    do_beat("t4_subnormal",     16'h0001, 16'h3C00, 1'b0, 16'h0000, 1'b0, 1'b0);
    do_beat("inf_plus_inf",     16'h7C00, 16'h7C00, 1'b0, 16'h7C00, 1'b1, 1'b0);
    do_beat("one_minus_inf",    16'h3C00, 16'h7C00, 1'b1, 16'hFC00, 1'b1, 1'b0);
    do_beat("zero_minus_one",   16'h0000, 16'h3C00, 1'b1, 16'hBC00, 1'b1, 1'b0);

    // Back-pressure: out_ready low for the first 3 cycles of the stream.
    n_acc = 0; n_rx = 0;
    for (int c = 0; c < 40 && n_rx < 4; c++) begin
      @(negedge clk);
      out_ready = (c >= 3);
      in_valid  = (n_acc < 4);
      in_a      = stream_a[n_acc < 4 ? n_acc : 3];
      in_b      = 16'h0000;
      in_sub    = 1'b0;
      #1;
      if (c == 2) begin
        chk("t5_in_ready_drop", 64'(in_ready), 64'd0);
        chk("t5_acc_before_drop", 64'(n_acc), 64'd2);
      end
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      if (fire_out) begin
        chk($sformatf("t5_order_%0d", n_rx), 64'(out_q), 64'(stream_a[n_rx]));
        n_rx++;
      end
      if (fire_in) n_acc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("t5_rx_count", 64'(n_rx), 64'd4);
    @(negedge clk);
    chk("t5_no_dup", 64'(out_valid), 64'd0);

    // Reset with two signalling-NaN beats stalled in the pipe.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_a = 16'h7D00; in_b = 16'h3C00; in_sub = 1'b0; in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("t6_full", 64'(out_valid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    chk("t6_out_valid", 64'(out_valid), 64'd0);
    chk("t6_flag_nv", 64'(flag_nv), 64'd0);
    repeat (3) @(negedge clk);
    chk("t6_no_replay", 64'(out_valid), 64'd0);
    chk("t6_flag_after", 64'(flag_nv), 64'd0);

    @(negedge clk);
    d_in_a = 32'h7F800000; d_in_b = 32'h7F800000; d_in_sub = 1'b1; d_in_valid = 1'b1;
    @(negedge clk);
    d_in_valid = 1'b0;
    @(negedge clk);
    chk("t6_sp_valid", 64'(d_out_valid), 64'd1);
    chk("t6_sp_q", 64'(d_out_q), 64'h7FC00000);
    chk("t6_sp_exc", 64'(d_out_exc), 64'd1);
    @(negedge clk);
    chk("t6_sp_nv", 64'(d_flag_nv), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
